// File: rtl/wdata_burst_fifo_if.sv
// Host-side write/read handshake and status bundle for the write-data burst FIFO.
interface wdata_burst_fifo_if #(
  parameter int DATA_W = 128,
  parameter int MASK_W = DATA_W / 8,
  parameter int AW     = 5
);
  logic              flush;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic [MASK_W-1:0] rmask;
  logic [AW:0]       count;
  logic              empty;
  logic              full;
  logic              afull;
  logic              burst_rdy;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output flush, wen, wdata, wmask, ren,
    input  rdata, rmask, count, empty, full, afull, burst_rdy, ovf_err, udf_err
  );

  modport slave (
    input  flush, wen, wdata, wmask, ren,
    output rdata, rmask, count, empty, full, afull, burst_rdy, ovf_err, udf_err
  );
endinterface

// File: rtl/wdata_burst_fifo.sv
// Write-data FIFO for the DDR write path: holds host beats and byte masks until
// the scheduler issues a WRITE burst. First-word-fall-through head, occupancy,
// almost-full, burst-ready, flush and sticky overflow/underflow flags.
module wdata_burst_fifo #(
  parameter int DATA_W    = 128,
  parameter int MASK_W    = DATA_W / 8,
  parameter int DEPTH     = 32,
  parameter int AW        = $clog2(DEPTH),
  parameter int AFULL_TH  = 2,
  parameter int BURST_LEN = 4
) (
  input logic              clk,
  input logic              rst_n,
  wdata_burst_fifo_if.slave bus
);

  // Thresholds narrowed to the count width; DEPTH is a power of two so it fits in AW+1 bits.
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_C = AFULL_TH[AW:0];
  localparam logic [AW:0] BURST_C = BURST_LEN[AW:0];

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count_w;
  logic              empty_w;
  logic              full_w;
  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [MASK_W-1:0] mem_mask [DEPTH];

  // Status derives purely from registered pointers; the extra wrap bit separates full from empty.
  assign count_w = wr_ptr - rd_ptr;
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

  // Both requests are judged against the pre-edge state; flush swallows them silently.
  assign push_ok = rst_n && !bus.flush && bus.wen && !full_w;
  assign pop_ok  = rst_n && !bus.flush && bus.ren && !empty_w;

  assign bus.count     = count_w;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.afull     = (DEPTH_C - count_w) < AFULL_C;
  assign bus.burst_rdy = (count_w >= BURST_C);
  assign bus.rdata     = empty_w ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign bus.rmask     = empty_w ? '0 : mem_mask[rd_ptr[AW-1:0]];

  // Pointer registers: reset and flush both rewind to zero, reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ovf_err <= 1'b0;
      bus.udf_err <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wen && full_w)  bus.ovf_err <= 1'b1;
      if (bus.ren && empty_w) bus.udf_err <= 1'b1;
    end
  end

  // Storage array is not reset; stale entries are unreachable once the pointers move.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr[AW-1:0]] <= bus.wdata;
      mem_mask[wr_ptr[AW-1:0]] <= bus.wmask;
    end
  end

endmodule

// File: tb/tb_wdata_burst_fifo.sv
// Self-checking bench for wdata_burst_fifo: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_wdata_burst_fifo;
  localparam int DATA_W    = 128;
  localparam int MASK_W    = 16;
  localparam int DEPTH     = 32;
  localparam int AW        = 5;
  localparam int AFULL_TH  = 2;
  localparam int BURST_LEN = 4;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [MASK_W-1:0] m;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ent_t q[$];
  bit   m_ovf = 1'b0;
  bit   m_udf = 1'b0;

  wdata_burst_fifo_if #(.DATA_W(DATA_W), .MASK_W(MASK_W), .AW(AW)) bus ();

  wdata_burst_fifo #(
    .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH), .AW(AW),
    .AFULL_TH(AFULL_TH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue updated from the inputs sampled at each rising edge.
  initial begin
    forever begin
      int sz;
      bit pu, po;
      @(posedge clk);
      sz = q.size();
      if (!rst_n) begin
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else if (bus.flush) begin
        q.delete();
      end else begin
        pu = bus.wen && (sz < DEPTH);
        po = bus.ren && (sz > 0);
        if (bus.wen && sz == DEPTH) m_ovf = 1'b1;
        if (bus.ren && sz == 0)     m_udf = 1'b1;
        if (po) void'(q.pop_front());
        if (pu) q.push_back({bus.wdata, bus.wmask});
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = q.size();
      chk("m_count", DATA_W'(bus.count), DATA_W'(sz));
      chk("m_empty", DATA_W'(bus.empty), DATA_W'(sz == 0));
      chk("m_full", DATA_W'(bus.full), DATA_W'(sz == DEPTH));
      chk("m_afull", DATA_W'(bus.afull), DATA_W'((DEPTH - sz) < AFULL_TH));
      chk("m_burst_rdy", DATA_W'(bus.burst_rdy), DATA_W'(sz >= BURST_LEN));
      chk("m_ovf", DATA_W'(bus.ovf_err), DATA_W'(m_ovf));
      chk("m_udf", DATA_W'(bus.udf_err), DATA_W'(m_udf));
      chk("m_rdata", bus.rdata, (sz > 0) ? q[0].d : '0);
      chk("m_rmask", DATA_W'(bus.rmask), (sz > 0) ? DATA_W'(q[0].m) : '0);
    end
  end

  task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit f);
    bus.wen   = w;
    bus.wdata = d;
    bus.wmask = MASK_W'(d[3:0]);
    bus.ren   = r;
    bus.flush = f;
    @(posedge clk);
    #1;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.flush = 1'b0;
    bus.wdata = '0; bus.wmask = '0;

    // 1: reset then idle
    rst_n = 1'b0;
    cyc(0, '0, 0, 0);
    chk_en = 1'b1;
    cyc(0, '0, 0, 0);
    rst_n = 1'b1;
    cyc(0, '0, 0, 0);
    chk("rst_empty", DATA_W'(bus.empty), 1);
    chk("rst_full", DATA_W'(bus.full), 0);
    chk("rst_count", DATA_W'(bus.count), 0);
    chk("rst_burst", DATA_W'(bus.burst_rdy), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_errs", DATA_W'({bus.ovf_err, bus.udf_err}), 0);

    // 2: fill 32, check afull/full, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, DATA_W'(i), 0, 0);
      if (i == 30) begin
        chk("fill31_count", DATA_W'(bus.count), 31);
        chk("fill31_afull", DATA_W'(bus.afull), 1);
        chk("fill31_full", DATA_W'(bus.full), 0);
      end
    end
    chk("fill32_full", DATA_W'(bus.full), 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_rdata", bus.rdata, DATA_W'(i));
      chk("drain_rmask", DATA_W'(bus.rmask), DATA_W'(i & 15));
      cyc(0, '0, 1, 0);
    end
    chk("drain_empty", DATA_W'(bus.empty), 1);

    // 3: burst-ready threshold
    for (int i = 0; i < 3; i++) cyc(1, DATA_W'(40 + i), 0, 0);
    chk("burst3", DATA_W'(bus.burst_rdy), 0);
    cyc(1, DATA_W'(43), 0, 0);
    chk("burst4", DATA_W'(bus.burst_rdy), 1);
    cyc(0, '0, 1, 0);
    chk("burst_pop", DATA_W'(bus.burst_rdy), 0);
    chk("burst_head", bus.rdata, 41);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);

    // 4: simultaneous push+pop on full, then on empty
    for (int i = 0; i < DEPTH; i++) cyc(1, DATA_W'(100 + i), 0, 0);
    cyc(1, DATA_W'(999), 1, 0);
    chk("fullrw_count", DATA_W'(bus.count), 31);
    chk("fullrw_ovf", DATA_W'(bus.ovf_err), 1);
    chk("fullrw_udf", DATA_W'(bus.udf_err), 0);
    chk("fullrw_head", bus.rdata, 101);
    for (int k = 0; k < 31; k++) begin
      chk("fullrw_seq", bus.rdata, DATA_W'(101 + k));
      cyc(0, '0, 1, 0);
    end
    chk("fullrw_empty", DATA_W'(bus.empty), 1);
    cyc(1, DATA_W'(77), 1, 0);
    chk("emptyrw_count", DATA_W'(bus.count), 1);
    chk("emptyrw_udf", DATA_W'(bus.udf_err), 1);
    chk("emptyrw_head", bus.rdata, 77);
    cyc(0, '0, 1, 0);

    // 5: wrap with steady occupancy of 5
    for (int i = 0; i < 5; i++) cyc(1, DATA_W'(500 + i), 0, 0);
    for (int k = 0; k < 100; k++) begin
      exp_d = (k < 5) ? DATA_W'(500 + k) : DATA_W'(600 + k - 5);
      chk("wrap_head", bus.rdata, exp_d);
      cyc(1, DATA_W'(600 + k), 1, 0);
      chk("wrap_count", DATA_W'(bus.count), 5);
    end
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);

    // 6: flush with traffic, then reset mid-traffic
    for (int i = 0; i < 10; i++) cyc(1, DATA_W'(800 + i), 0, 0);
    chk("preflush_count", DATA_W'(bus.count), 10);
    cyc(1, DATA_W'(900), 0, 1);
    chk("flush_count", DATA_W'(bus.count), 0);
    chk("flush_empty", DATA_W'(bus.empty), 1);
    chk("flush_rdata", bus.rdata, 0);
    chk("flush_errs", DATA_W'({bus.ovf_err, bus.udf_err}), 3);
    for (int i = 0; i < 6; i++) cyc(1, DATA_W'(700 + i), 0, 0);
    chk("postflush_head", bus.rdata, 700);
    rst_n = 1'b0;
    cyc(1, DATA_W'(950), 1, 0);
    rst_n = 1'b1;
    chk("rstmid_count", DATA_W'(bus.count), 0);
    chk("rstmid_errs", DATA_W'({bus.ovf_err, bus.udf_err}), 0);
    chk("rstmid_empty", DATA_W'(bus.empty), 1);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
